// File: rtl/ibex_bus_responder.sv
// Memory-backed responder for an Ibex-style req/gnt/rvalid data port.
// Fixed-latency response pipeline with a bounded number of outstanding requests.
module ibex_bus_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] ErrBase        = 32'hFFFF_F000,
    parameter logic [31:0] ErrMask        = 32'hFFFF_F000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [3:0]  outstanding_o
);

    localparam int unsigned AW = $clog2(MemWords);

    // Handshake: a transaction is accepted in any cycle with req_i & gnt_o;
    // its response appears as a one-cycle rvalid_o pulse Latency cycles later.
    logic [31:0] r_mem        [MemWords];
    logic        r_pipe_valid [Latency];
    logic        r_pipe_err   [Latency];
    logic [31:0] r_pipe_rdata [Latency];
    logic [3:0]  r_outstanding;

    logic          w_accept;
    logic          w_err;
    logic          w_room;
    logic [3:0]    w_out_eff;
    logic [AW-1:0] w_idx;

    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign w_out_eff = r_outstanding - {3'b000, rvalid_o};
    assign w_room    = (w_out_eff < 4'(MaxOutstanding));
    assign gnt_o     = req_i & ~stall_i & ~rst_i & w_room;
    assign w_accept  = req_i & gnt_o;
    assign w_idx     = addr_i[AW+1:2];
    assign w_err     = ((addr_i & ErrMask) == ErrBase) |
                       ({2'b00, addr_i[31:2]} >= 32'(MemWords));

    always_ff @(posedge clk_i) begin
        if (w_accept & we_i & ~w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Valid bits clear asynchronously so in-flight responses are dropped on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                r_pipe_valid[i] <= 1'b0;
            end
        end else begin
            r_pipe_valid[0] <= w_accept;
            for (int i = 1; i < Latency; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_pipe_err[0]   <= w_err;
        r_pipe_rdata[0] <= (w_accept & ~we_i & ~w_err) ? r_mem[w_idx] : 32'h0;
        for (int i = 1; i < Latency; i++) begin
            r_pipe_err[i]   <= r_pipe_err[i-1];
            r_pipe_rdata[i] <= r_pipe_rdata[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= 4'd0;
        end else begin
            case ({w_accept, rvalid_o})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign rvalid_o      = r_pipe_valid[Latency-1];
    assign rdata_o       = rvalid_o ? r_pipe_rdata[Latency-1] : 32'h0;
    assign err_o         = rvalid_o & r_pipe_err[Latency-1];
    assign outstanding_o = r_outstanding;

endmodule

// File: doc/ibex_bus_responder.md
IBEX_BUS_RESPONDER -- requirements
Module: ibex_bus_responder

Interface
REQ-001 SHALL have parameter MemWords, default 1024, number of 32-bit words in the backing store (power of two, >= 4).
REQ-002 SHALL have parameter Latency, default 1, cycles from grant to response (legal 1..8).
REQ-003 SHALL have parameter MaxOutstanding, default 2, maximum granted-but-unanswered requests (legal 1..8).
REQ-004 SHALL have parameters ErrBase, default 32'hFFFF_F000, and ErrMask, default 32'hFFFF_F000, which together define the error address window.
REQ-005 SHALL have port clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_i  input  1  request valid from the core.
REQ-008 SHALL have port addr_i  input  32  byte address; bits [1:0] are ignored.
REQ-009 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port be_i  input  4  byte enables for writes.
REQ-011 SHALL have port wdata_i  input  32  write data.
REQ-012 SHALL have port stall_i  input  1  test hook that suppresses grant.
REQ-013 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-014 SHALL have port rvalid_o  output  1  response valid.
REQ-015 SHALL have port rdata_o  output  32  read data, qualified by rvalid_o.
REQ-016 SHALL have port err_o  output  1  error response, qualified by rvalid_o.
REQ-017 SHALL have port outstanding_o  output  4  current outstanding count (debug).

Function
REQ-018 SHALL drive gnt_o combinationally as req_i & ~stall_i & (outstanding_q - rvalid_o < MaxOutstanding), so that a slot freed by a response in the same cycle can be reused.
REQ-019 SHALL treat a cycle with req_i & gnt_o as an accepted transaction; it SHALL sample addr_i, we_i, be_i and wdata_i only in that cycle.
REQ-020 SHALL classify a transaction as an error if (addr_i & ErrMask) == ErrBase, or if addr_i[31:2] >= MemWords.
REQ-021 For an accepted non-error write, SHALL update only the bytes whose be_i bit is set, at the end of the accept cycle.
REQ-022 For an accepted non-error read, SHALL capture the addressed word in the accept cycle, including any write accepted in the previous cycle (read-after-write ordering).
REQ-023 SHALL assert rvalid_o for exactly one cycle, exactly Latency cycles after the accept cycle; responses SHALL be in acceptance order.
REQ-024 SHALL implement the response timing as a Latency-deep pipeline of {valid, err, rdata} entries; back-to-back accepts SHALL produce back-to-back responses.
REQ-025 For error transactions, SHALL assert err_o=1 with rdata_o=0, and SHALL leave memory unmodified.
REQ-026 For write responses, SHALL drive rdata_o=0 and err_o=0.
REQ-027 When rvalid_o=0, SHALL drive rdata_o=0 and err_o=0.
REQ-028 SHALL update outstanding_q as +1 on accept, -1 on rvalid_o, and unchanged when both occur in the same cycle; it SHALL never exceed MaxOutstanding and never underflow.
REQ-029 SHALL keep outstanding_o equal to outstanding_q.
REQ-030 SHALL accept requests while stall_i=1 toggles without corrupting in-flight responses; stall_i affects only gnt_o.
REQ-031 SHALL allow a new request in the same cycle that the previous transaction's response is issued.

Reset
REQ-032 While rst_i=1, SHALL hold gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0 and outstanding_o=0.
REQ-033 SHALL clear all pipeline valid bits immediately on rst_i assertion; in-flight responses SHALL be discarded and never issued.
REQ-034 SHALL NOT reset memory contents; benches SHALL write locations before reading them.
REQ-035 SHALL be able to accept a request in the first cycle after rst_i deasserts.

Verification
REQ-036 Latency=1: write 0xDEADBEEF to addr 0x10 with be=4'hF, then read 0x10 -> gnt in the same cycle as each request; read rvalid one cycle after its gnt with rdata=0xDEADBEEF, err=0.
REQ-037 Byte enables: with 0x11223344 at addr 0x20, write 0xAABBCCDD with be=4'b0101, then read -> rdata=0x11BB33DD.
REQ-038 Latency=3, MaxOutstanding=2, req_i held high: gnt cycles 0,1 then 3,4; rvalid cycles 3,4 then 6,7; outstanding_o never exceeds 2.
REQ-039 Read addr 0xFFFF_F004 and read addr 4*MemWords -> each gives rvalid with err=1, rdata=0; a preceding write to 0xFFFF_F004 does not alter any memory word.
REQ-040 Latency=4: accept 2 reads, assert rst_i for 1 cycle at cycle 2 -> no rvalid ever issued for them; outstanding_o=0; a new read after reset is answered correctly.
REQ-041 stall_i=1 for 5 cycles with req_i=1 -> gnt_o=0 throughout; on release, gnt_o=1 in the same cycle and rvalid arrives Latency cycles later.
